// File: rtl/ext_conv_buf.sv
// ext_conv_buf
//   Converts an INPUT_TYPE-bit integer token to OUTPUT_TYPE bits (zero, sign
//   or signed-saturating conversion, widening or narrowing), then holds the
//   result in a two-slot skid buffer. The buffer cuts the datapath and
//   registers ready, and still sustains one token per cycle.
//
// Ports
//   clk         in   rising-edge clock
//   rst         in   asynchronous active-low reset
//   ins         in   [INPUT_TYPE-1:0]  input token
//   ins_valid   in   input token valid
//   ins_ready   out  input may be accepted (decoded from state only)
//   outs        out  [OUTPUT_TYPE-1:0] converted token
//   outs_ovf    out  converted value differs from the input's value
//   outs_valid  out  output token valid (decoded from state only)
//   outs_ready  in   consumer accepts
module ext_conv_buf #(
    parameter int INPUT_TYPE  = 32,
    parameter int OUTPUT_TYPE = 64,
    parameter int MODE        = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [INPUT_TYPE-1:0]  ins,
    input  logic                   ins_valid,
    output logic                   ins_ready,
    output logic [OUTPUT_TYPE-1:0] outs,
    output logic                   outs_ovf,
    output logic                   outs_valid,
    input  logic                   outs_ready
);

    localparam int I = INPUT_TYPE;
    localparam int O = OUTPUT_TYPE;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    // Slot layout: {ovf, data}
    logic [O:0] conv;

    if (MODE > 2) begin : g_bad_mode
        $error("ext_conv_buf: MODE must be 0, 1 or 2");
    end

    if (O == I) begin : g_pass
        assign conv = {1'b0, ins};
    end else if (O > I) begin : g_widen
        if (MODE == 0) begin : g_zext
            assign conv = {1'b0, {(O - I){1'b0}}, ins};
        end else begin : g_sext
            assign conv = {1'b0, {(O - I){ins[I-1]}}, ins};
        end
    end else begin : g_narrow
        if (MODE == 0) begin : g_trunc_u
            assign conv = {(|ins[I-1:O]), ins[O-1:0]};
        end else if (MODE == 1) begin : g_trunc_s
            // The value fits iff the dropped bits plus the new sign bit agree.
            logic [I-O:0] hi;
            assign hi   = ins[I-1:O-1];
            assign conv = {~((&hi) | ~(|hi)), ins[O-1:0]};
        end else begin : g_sat
            localparam logic [O-1:0] MIN_V = O'(1) << (O - 1);
            localparam logic [O-1:0] MAX_V = ~MIN_V;

            function automatic logic [O:0] sat_narrow(input logic [I-1:0] x);
                logic [I-O:0] hi;
                hi = x[I-1:O-1];
                if ((&hi) || !(|hi)) begin
                    return {1'b0, x[O-1:0]};
                end else if (x[I-1]) begin
                    return {1'b1, MIN_V};
                end else begin
                    return {1'b1, MAX_V};
                end
            endfunction

            assign conv = sat_narrow(ins);
        end
    end

    state_t     state_q, state_d;
    logic [O:0] main_q, main_d;
    logic [O:0] skid_q, skid_d;
    logic       in_fire, out_fire;

    assign ins_ready  = (state_q != FULL);
    assign outs_valid = (state_q != EMPTY);
    assign outs       = main_q[O-1:0];
    assign outs_ovf   = main_q[O];

    assign in_fire  = ins_valid & ins_ready;
    assign out_fire = outs_valid & outs_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        case (state_q)
            EMPTY: begin
                if (in_fire) begin
                    state_d = ONE;
                    main_d  = conv;
                end
            end
            ONE: begin
                if (in_fire && !out_fire) begin
                    state_d = FULL;
                    skid_d  = conv;
                end else if (in_fire && out_fire) begin
                    main_d = conv;
                end else if (out_fire) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                // No input is accepted here, so the skid slot simply drains.
                if (out_fire) begin
                    state_d = ONE;
                    main_d  = skid_q;
                end
            end
            default: begin
                state_d = EMPTY;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

endmodule

// File: tb/tb_ext_conv_buf.sv
module tb_ext_conv_buf;

    logic        clk;
    logic        rst;
    logic        ins_valid;
    logic        outs_ready;
    logic [7:0]  ins8;
    logic [15:0] ins16;

    logic [15:0] s816_outs, u816_outs;
    logic [7:0]  n0_outs, n1_outs, n2_outs;
    logic        s816_ovf, u816_ovf, n0_ovf, n1_ovf, n2_ovf;
    logic        s816_vld, u816_vld, n0_vld, n1_vld, n2_vld;
    logic        s816_rdy, u816_rdy, n0_rdy, n1_rdy, n2_rdy;

    int n_tests = 0;
    int n_fail  = 0;

    ext_conv_buf #(.INPUT_TYPE(8), .OUTPUT_TYPE(16), .MODE(1)) u_s816 (
        .clk(clk), .rst(rst), .ins(ins8), .ins_valid(ins_valid), .ins_ready(s816_rdy),
        .outs(s816_outs), .outs_ovf(s816_ovf), .outs_valid(s816_vld), .outs_ready(outs_ready));
    ext_conv_buf #(.INPUT_TYPE(8), .OUTPUT_TYPE(16), .MODE(0)) u_u816 (
        .clk(clk), .rst(rst), .ins(ins8), .ins_valid(ins_valid), .ins_ready(u816_rdy),
        .outs(u816_outs), .outs_ovf(u816_ovf), .outs_valid(u816_vld), .outs_ready(outs_ready));
    ext_conv_buf #(.INPUT_TYPE(16), .OUTPUT_TYPE(8), .MODE(0)) u_n0 (
        .clk(clk), .rst(rst), .ins(ins16), .ins_valid(ins_valid), .ins_ready(n0_rdy),
        .outs(n0_outs), .outs_ovf(n0_ovf), .outs_valid(n0_vld), .outs_ready(outs_ready));
    ext_conv_buf #(.INPUT_TYPE(16), .OUTPUT_TYPE(8), .MODE(1)) u_n1 (
        .clk(clk), .rst(rst), .ins(ins16), .ins_valid(ins_valid), .ins_ready(n1_rdy),
        .outs(n1_outs), .outs_ovf(n1_ovf), .outs_valid(n1_vld), .outs_ready(outs_ready));
    ext_conv_buf #(.INPUT_TYPE(16), .OUTPUT_TYPE(8), .MODE(2)) u_n2 (
        .clk(clk), .rst(rst), .ins(ins16), .ins_valid(ins_valid), .ins_ready(n2_rdy),
        .outs(n2_outs), .outs_ovf(n2_ovf), .outs_valid(n2_vld), .outs_ready(outs_ready));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: run did not finish, act=timeout req=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Conversion vectors, all instances driven at once
    localparam int NV = 6;
    logic [7:0]  v8    [NV] = '{8'h80, 8'h7F, 8'h00, 8'hFF, 8'h01, 8'h80};
    logic [15:0] e_s   [NV] = '{16'hFF80, 16'h007F, 16'h0000, 16'hFFFF, 16'h0001, 16'hFF80};
    logic [15:0] e_u   [NV] = '{16'h0080, 16'h007F, 16'h0000, 16'h00FF, 16'h0001, 16'h0080};
    logic [15:0] v16   [NV] = '{16'hFF7F, 16'h007F, 16'h0200, 16'hFE00, 16'hFFF0, 16'h0100};
    logic [7:0]  e0    [NV] = '{8'h7F, 8'h7F, 8'h00, 8'h00, 8'hF0, 8'h00};
    logic        e0o   [NV] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    logic [7:0]  e1    [NV] = '{8'h7F, 8'h7F, 8'h00, 8'h00, 8'hF0, 8'h00};
    logic        e1o   [NV] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    logic [7:0]  e2    [NV] = '{8'h80, 8'h7F, 8'h7F, 8'h80, 8'hF0, 8'h7F};
    logic        e2o   [NV] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

    initial begin
        rst        = 1'b0;
        ins_valid  = 1'b1;
        outs_ready = 1'b0;
        ins8       = 8'h55;
        ins16      = 16'h1234;

        // Reset held with a valid token offered
        tick();
        tick();
        check("rst_vld", 64'(n2_vld), 64'd0);
        check("rst_rdy", 64'(n2_rdy), 64'd1);
        check("rst_outs", 64'(n2_outs), 64'd0);
        check("rst_ovf", 64'(n2_ovf), 64'd0);
        check("rst_vld_s816", 64'(s816_vld), 64'd0);

        rst   = 1'b1;
        ins16 = 16'h0042;
        tick();
        check("first_vld", 64'(n2_vld), 64'd1);
        check("first_outs", 64'(n2_outs), 64'h42);
        ins_valid  = 1'b0;
        outs_ready = 1'b1;
        tick();
        check("drain_vld", 64'(n2_vld), 64'd0);

        // Conversion table
        ins_valid = 1'b1;
        for (int k = 0; k < NV; k++) begin
            ins8  = v8[k];
            ins16 = v16[k];
            tick();
            check($sformatf("s816_%0d", k), 64'(s816_outs), 64'(e_s[k]));
            check($sformatf("s816_ovf_%0d", k), 64'(s816_ovf), 64'd0);
            check($sformatf("u816_%0d", k), 64'(u816_outs), 64'(e_u[k]));
            check($sformatf("u816_ovf_%0d", k), 64'(u816_ovf), 64'd0);
            check($sformatf("n0_%0d", k), 64'(n0_outs), 64'(e0[k]));
            check($sformatf("n0_ovf_%0d", k), 64'(n0_ovf), 64'(e0o[k]));
            check($sformatf("n1_%0d", k), 64'(n1_outs), 64'(e1[k]));
            check($sformatf("n1_ovf_%0d", k), 64'(n1_ovf), 64'(e1o[k]));
            check($sformatf("n2_%0d", k), 64'(n2_outs), 64'(e2[k]));
            check($sformatf("n2_ovf_%0d", k), 64'(n2_ovf), 64'(e2o[k]));
        end
        ins_valid = 1'b0;
        tick();
        check("tbl_drain_vld", 64'(n2_vld), 64'd0);

        // Streaming 1..10 at full rate
        ins_valid  = 1'b1;
        outs_ready = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            ins16 = 16'(k);
            check($sformatf("strm_rdy_%0d", k), 64'(n2_rdy), 64'd1);
            tick();
            check($sformatf("strm_vld_%0d", k), 64'(n2_vld), 64'd1);
            check($sformatf("strm_outs_%0d", k), 64'(n2_outs), 64'(k));
        end
        ins_valid = 1'b0;
        tick();
        check("strm_end_vld", 64'(n2_vld), 64'd0);

        // Backpressure: A, B buffered, C stalled
        outs_ready = 1'b0;
        ins_valid  = 1'b1;
        ins16      = 16'h000A;
        tick();
        check("bp_a_outs", 64'(n2_outs), 64'h0A);
        check("bp_a_rdy", 64'(n2_rdy), 64'd1);
        ins16 = 16'h000B;
        tick();
        check("bp_full_rdy", 64'(n2_rdy), 64'd0);
        check("bp_full_outs", 64'(n2_outs), 64'h0A);
        ins16 = 16'h000C;
        tick();
        check("bp_stall_rdy", 64'(n2_rdy), 64'd0);
        check("bp_stall_outs", 64'(n2_outs), 64'h0A);
        check("bp_stall_vld", 64'(n2_vld), 64'd1);
        outs_ready = 1'b1;
        tick();
        check("bp_b_outs", 64'(n2_outs), 64'h0B);
        check("bp_b_rdy", 64'(n2_rdy), 64'd1);
        tick();
        check("bp_c_outs", 64'(n2_outs), 64'h0C);
        check("bp_c_vld", 64'(n2_vld), 64'd1);
        ins_valid = 1'b0;
        tick();
        check("bp_empty_vld", 64'(n2_vld), 64'd0);

        // Asynchronous reset while FULL
        outs_ready = 1'b0;
        ins_valid  = 1'b1;
        ins16      = 16'h0011;
        tick();
        ins16 = 16'h0022;
        tick();
        check("ar_full_rdy", 64'(n2_rdy), 64'd0);
        #2;
        rst = 1'b0;
        #1;
        check("ar_vld", 64'(n2_vld), 64'd0);
        check("ar_rdy", 64'(n2_rdy), 64'd1);
        check("ar_outs", 64'(n2_outs), 64'd0);
        ins_valid = 1'b0;
        tick();
        rst        = 1'b1;
        outs_ready = 1'b1;
        tick();
        check("ar_post_vld", 64'(n2_vld), 64'd0);
        ins_valid = 1'b1;
        ins16     = 16'h0033;
        tick();
        check("ar_new_outs", 64'(n2_outs), 64'h33);
        ins_valid = 1'b0;
        tick();
        check("ar_new_drain", 64'(n2_vld), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ext_conv_buf.md
Name: ext_conv_buf

Overview:
- Parametrised successor to the combinational integer extension units.
- Converts an INPUT_TYPE-bit integer token to OUTPUT_TYPE bits in one of three modes: zero, sign or saturating, for widening and narrowing.
- Registers the result in a two-slot skid buffer, so the datapath is cut and ready is registered while throughput stays at full rate.
- Sits on elastic valid/ready channels between arithmetic units in generated dataflow circuits.

Parameters:
- INPUT_TYPE, 32: input data width in bits, >=1.
- OUTPUT_TYPE, 64: output data width in bits, >=1. May be less than, equal to or greater than INPUT_TYPE.
- MODE, 1: 0 = unsigned (zero-extend / truncate); 1 = signed (sign-extend / truncate); 2 = signed saturating (sign-extend / clamp).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous active-low reset.
- ins  in  INPUT_TYPE  input data.
- ins_valid  in  1  input token valid.
- ins_ready  out  1  input may be accepted.
- outs  out  OUTPUT_TYPE  converted data.
- outs_ovf  out  1  the converted value differs from the input's mathematical value (travels with the token).
- outs_valid  out  1  output token valid.
- outs_ready  in  1  consumer accepts.

Behaviour:
- Reset: rst=0 asynchronously forces state EMPTY, outs=0, outs_ovf=0, outs_valid=0 and ins_ready=1. This holds mid-transfer; in-flight tokens are discarded.
- Handshake: in_fire = ins_valid & ins_ready; out_fire = outs_valid & outs_ready.
- outs_valid and ins_ready are decoded from state registers only. There is no combinational path from ins_valid to outs_valid or from outs_ready to ins_ready.
- Storage: main slot (drives outs/outs_ovf) and skid slot, each holding {data, ovf}.
- outs_valid = (state != EMPTY); ins_ready = (state != FULL).
- States and transitions:
  - EMPTY: in_fire -> ONE, conversion written to main.
  - ONE, in_fire & !out_fire -> FULL, conversion written to skid, main held.
  - ONE, in_fire & out_fire -> ONE, main overwritten with new conversion.
  - ONE, !in_fire & out_fire -> EMPTY.
  - ONE, neither -> ONE, held.
  - FULL: out_fire -> ONE, skid moved to main; otherwise held. No input is accepted in FULL.
- Latency: a token accepted at edge N is visible on outs after edge N. Minimum in-to-out latency is 1 cycle.
- Throughput: 1 token/cycle sustained when outs_ready=1.
- Under backpressure, exactly 2 tokens are buffered. FIFO order is always preserved.
- outs/outs_ovf remain stable while outs_valid=1 and outs_ready=0.
- Conversion, with I=INPUT_TYPE and O=OUTPUT_TYPE:
  - O==I: passthrough, ovf=0, for all modes.
  - O>I, MODE 0: zero-extend, ovf=0.
  - O>I, MODE 1/2: replicate ins[I-1], ovf=0.
  - O<I, MODE 0: outs=ins[O-1:0]; ovf = |ins[I-1:O].
  - O<I, MODE 1: outs=ins[O-1:0]; ovf=1 unless ins[I-1:O-1] is all-zeros or all-ones.
  - O<I, MODE 2: clamp signed value to [-2^(O-1), 2^(O-1)-1]. ovf=1 when clamped, else low bits are passed.
- Conversion is applied at write time. Stored values never re-evaluate.
- Data registers need no reset for function, but are reset to 0 for deterministic X-free simulation.
- Illegal MODE values (>2) are a compile-time error (generate-time assertion).

Test Plan:
- Reset: hold rst=0 with ins_valid=1 -> outs_valid=0, ins_ready=1, outs=0. Deassert rst -> first accepted token appears one cycle later.
- Sign widen (I=8, O=16, MODE 1): ins=0x80 -> outs=0xFF80, ovf=0. With MODE 0, same input -> outs=0x0080.
- Narrow (I=16, O=8):
  - MODE 1: 0xFF7F -> outs=0x7F, ovf=1. 0x007F -> outs=0x7F, ovf=0.
  - MODE 2: 0x0200 -> outs=0x7F, ovf=1. 0xFE00 -> outs=0x80, ovf=1. 0xFFF0 -> outs=0xF0, ovf=0.
  - MODE 0: 0x0100 -> outs=0x00, ovf=1.
- Streaming: outs_ready=1, send 10 tokens 1..10 back-to-back -> ins_ready stays 1, outs shows 1..10 on consecutive cycles starting 1 cycle after the first accept.
- Backpressure: outs_ready=0, offer tokens A,B,C -> A and B accepted, ins_ready=0 with C stalled. Raise outs_ready for 3 cycles -> A, B, C emitted in order, no loss or duplication, outs stable while stalled.
- Async reset in FULL mid-stream: pull rst low between edges -> outs_valid drops immediately without a clock edge, buffered tokens are dropped, and state is EMPTY after release.
